// File: rtl/wgt_feeder.sv
// ---------------------------------------------------------------------------
// wgt_feeder
//   Streams NUM_WGT signed weights from a synchronous weight memory into the
//   weight buffer. Each start command captures a base address. The block then
//   issues reads at base_addr + n. A 2-entry FIFO absorbs the one-cycle memory
//   latency and the stall back-pressure, so the stream keeps one weight per
//   cycle when stall is low and can never overflow when stall is high.
// ---------------------------------------------------------------------------
module wgt_feeder #(
    parameter int NUM_WGT = 4,   // weights per start command, 1..255
    parameter int ADDR_W  = 10   // weight-memory address width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     start,
    input  logic        [ADDR_W-1:0] base_addr,
    output logic                     mem_ren,
    output logic        [ADDR_W-1:0] mem_addr,
    input  logic signed [7:0]        mem_rdata,
    output logic                     wgt_read,
    output logic signed [7:0]        wgt_input,
    output logic                     busy,
    output logic                     done
);

    // Counters must hold the value NUM_WGT itself. The issue counter stops there.
    localparam int                 CNT_W    = $clog2(NUM_WGT + 1);
    localparam logic [CNT_W-1:0]   NUM_C    = CNT_W'(NUM_WGT);
    localparam logic [CNT_W-1:0]   LAST_C   = CNT_W'(NUM_WGT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q,       state_d;
    logic       [ADDR_W-1:0] base_q,        base_d;
    logic       [CNT_W-1:0]  issue_cnt_q,   issue_cnt_d;
    logic       [CNT_W-1:0]  consume_cnt_q, consume_cnt_d;
    logic                    inflight_q;

    // Output FIFO: two entries with a read and a write pointer, plus an occupancy count.
    logic signed [7:0]       fifo_mem_q [2];
    logic                    wr_ptr_q,      wr_ptr_d;
    logic                    rd_ptr_q,      rd_ptr_d;
    logic        [1:0]       fifo_cnt_q,    fifo_cnt_d;

    logic                    push;
    logic                    pop;
    logic        [2:0]       occ_after;

    // FIFO handshake terms. The weight buffer shifts exactly when pop is high.
    always_comb begin
        push      = inflight_q;
        pop       = (fifo_cnt_q != 2'd0) && !stall;
        // pop implies fifo_cnt_q >= 1, so this never underflows
        occ_after = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    end

    // Read issue. A read goes out only if the FIFO still has a free entry
    // when the data returns.
    always_comb begin
        mem_ren  = (state_q == S_RUN) && (issue_cnt_q < NUM_C) && (occ_after < 3'd2);
        mem_addr = base_q + ADDR_W'(issue_cnt_q);
    end

    // FIFO-facing outputs: the FIFO head is presented whenever the FIFO holds data.
    always_comb begin
        wgt_read  = (fifo_cnt_q != 2'd0);
        wgt_input = fifo_mem_q[rd_ptr_q];
    end

    // FSM next-state and status outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; otherwise a
        // path that skips an assignment would infer a latch.
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (pop && (consume_cnt_q == LAST_C)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;   // one cycle only, stall has no effect
            default: state_d = S_IDLE;
        endcase
    end

    // Next-state logic for the base address and the counters. An accepted
    // start resets both counters.
    always_comb begin
        base_d        = base_q;
        issue_cnt_d   = issue_cnt_q;
        consume_cnt_d = consume_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            base_d        = base_addr;
            issue_cnt_d   = '0;
            consume_cnt_d = '0;
        end else begin
            if (mem_ren) issue_cnt_d   = issue_cnt_q + 1'b1;
            if (pop)     consume_cnt_d = consume_cnt_q + 1'b1;
        end
    end

    // Next-state logic for the FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State, counters and in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together at the edge, whatever order the statements run in.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            consume_cnt_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            issue_cnt_q   <= issue_cnt_d;
            consume_cnt_q <= consume_cnt_d;
            inflight_q    <= mem_ren;
        end
    end

    // FIFO storage and pointers. Returning read data is always written, even
    // when stall is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two FIFO entries are reset on purpose, because the head
            // entry drives wgt_input directly and that output must read 0 during reset.
            for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_wgt_feeder.sv
// ---------------------------------------------------------------------------
// tb_wgt_feeder
//   Directed bench for wgt_feeder. u_dut has NUM_WGT=4 and runs the
//   cycle-exact scenarios. u_dut8 has NUM_WGT=8 and runs under random stall
//   against a scoreboard. Both instances read one shared memory model that
//   returns data one cycle after a read.
// ---------------------------------------------------------------------------
module tb_wgt_feeder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;

    logic              stall, start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              wgt_read;
    logic [7:0]        wgt_input;
    logic              busy, done;

    logic              stall8, start8;
    logic [ADDR_W-1:0] base8;
    logic              mem_ren8;
    logic [ADDR_W-1:0] mem_addr8;
    logic [7:0]        mem_rdata8;
    logic              wgt_read8;
    logic [7:0]        wgt_input8;
    logic              busy8, done8;

    logic [7:0]        mem [1024];

    int n_cmp   = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int ren100   = 0;

    typedef struct {
        logic              st;
        logic [ADDR_W-1:0] sb;
        logic              stl;
        logic              ren;
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic [7:0]        w;
        logic              dn;
        logic              bz;
    } cyc_t;

    cyc_t tbl[$];

    always #5 clk = ~clk;

    wgt_feeder #(.NUM_WGT(4), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .start(start),
        .base_addr(base_addr), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .wgt_read(wgt_read), .wgt_input(wgt_input),
        .busy(busy), .done(done)
    );

    wgt_feeder #(.NUM_WGT(8), .ADDR_W(ADDR_W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .stall(stall8), .start(start8),
        .base_addr(base8), .mem_ren(mem_ren8), .mem_addr(mem_addr8),
        .mem_rdata(mem_rdata8), .wgt_read(wgt_read8), .wgt_input(wgt_input8),
        .busy(busy8), .done(done8)
    );

    // Synchronous memory model. Data appears one cycle after the read; a
    // filler value is driven otherwise.
    always @(posedge clk) begin
        mem_rdata  <= mem_ren  ? mem[mem_addr]  : 8'hC3;
        mem_rdata8 <= mem_ren8 ? mem[mem_addr8] : 8'hC3;
    end

    // Event monitors on u_dut: done pulses and any read of address 0x100.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_ren && (mem_addr == 10'h100)) ren100 <= ren100 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic add(input logic st, input logic [ADDR_W-1:0] sb, input logic stl,
                       input logic ren, input logic [ADDR_W-1:0] addr,
                       input logic rd, input logic [7:0] w, input logic dn, input logic bz);
        cyc_t c;
        c.st = st; c.sb = sb; c.stl = stl; c.ren = ren; c.addr = addr;
        c.rd = rd; c.w = w; c.dn = dn; c.bz = bz;
        tbl.push_back(c);
    endtask

    // Unstalled load, cycles C1..C8 after the start cycle C0.
    task automatic build_nominal(input logic [ADDR_W-1:0] b,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3);
        tbl.delete();
        add(1'b0, b, 1'b0, 1'b1, b,          1'b0, 8'h00, 1'b0, 1'b1); // C1
        add(1'b0, b, 1'b0, 1'b1, b + 10'd1,  1'b0, 8'h00, 1'b0, 1'b1); // C2
        add(1'b0, b, 1'b0, 1'b1, b + 10'd2,  1'b1, d0,    1'b0, 1'b1); // C3
        add(1'b0, b, 1'b0, 1'b1, b + 10'd3,  1'b1, d1,    1'b0, 1'b1); // C4
        add(1'b0, b, 1'b0, 1'b0, 10'h000,    1'b1, d2,    1'b0, 1'b1); // C5
        add(1'b0, b, 1'b0, 1'b0, 10'h000,    1'b1, d3,    1'b0, 1'b1); // C6
        add(1'b0, b, 1'b0, 1'b0, 10'h000,    1'b0, 8'h00, 1'b1, 1'b1); // C7
        add(1'b0, b, 1'b0, 1'b0, 10'h000,    1'b0, 8'h00, 1'b0, 1'b0); // C8
    endtask

    task automatic exp_cyc(input string tag, input cyc_t c);
        check({tag, ".mem_ren"}, 32'(mem_ren), 32'(c.ren));
        if (c.ren) check({tag, ".mem_addr"}, 32'(mem_addr), 32'(c.addr));
        check({tag, ".wgt_read"}, 32'(wgt_read), 32'(c.rd));
        if (c.rd) check({tag, ".wgt_input"}, 32'(wgt_input), 32'(c.w));
        check({tag, ".done"}, 32'(done), 32'(c.dn));
        check({tag, ".busy"}, 32'(busy), 32'(c.bz));
    endtask

    // Start cycle C0: the request is driven, and the block is still idle.
    task automatic launch(input string name, input logic [ADDR_W-1:0] b);
        next_cycle();
        start = 1'b1; base_addr = b; stall = 1'b0;
        sample();
        check({name, ".C0.busy"}, 32'(busy), 32'd0);
        check({name, ".C0.mem_ren"}, 32'(mem_ren), 32'd0);
    endtask

    task automatic play(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            start = tbl[i].st; base_addr = tbl[i].sb; stall = tbl[i].stl;
            sample();
            exp_cyc($sformatf("%s.C%0d", name, i + 1), tbl[i]);
        end
    endtask

    task automatic idle_check(input string name);
        check({name, ".mem_ren"}, 32'(mem_ren), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".done"}, 32'(done), 32'd0);
        check({name, ".wgt_read"}, 32'(wgt_read), 32'd0);
    endtask

    // Random-stall load on u_dut8, checked against the memory contents.
    task automatic rnd_load(input string name, input logic [ADDR_W-1:0] b);
        int  issued   = 0;
        int  consumed = 0;
        int  dn       = 0;
        bit  finished = 0;
        next_cycle();
        start8 = 1'b1; base8 = b; stall8 = 1'b0;
        sample();
        next_cycle();
        start8 = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            stall8 = 1'($urandom_range(0, 1));
            sample();
            check({name, ".occupancy_le2"}, 32'((issued - consumed) <= 2), 32'd1);
            if (mem_ren8) begin
                check($sformatf("%s.addr%0d", name, issued), 32'(mem_addr8),
                      32'(10'(b + 10'(issued))));
                issued++;
            end
            if (wgt_read8 && !stall8) begin
                check($sformatf("%s.wgt%0d", name, consumed), 32'(wgt_input8),
                      32'(mem[10'(b + 10'(consumed))]));
                consumed++;
            end
            if (done8) begin
                dn++;
                finished = 1;
                check({name, ".consumed_at_done"}, 32'(consumed), 32'd8);
            end
            next_cycle();
        end
        check({name, ".done_seen"}, 32'(dn), 32'd1);
        for (int k = 0; k < 3; k++) begin
            stall8 = 1'($urandom_range(0, 1));
            sample();
            check({name, ".post.done"}, 32'(done8), 32'd0);
            check({name, ".post.busy"}, 32'(busy8), 32'd0);
            check({name, ".post.mem_ren"}, 32'(mem_ren8), 32'd0);
            if (k < 2) next_cycle();
        end
        check({name, ".issued"}, 32'(issued), 32'd8);
        check({name, ".consumed"}, 32'(consumed), 32'd8);
    endtask

    initial begin
        int d0;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5);
        mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'hFF; mem[10'h013] = 8'h80;
        mem[10'h3FE] = 8'h5A; mem[10'h3FF] = 8'hA5; mem[10'h000] = 8'h01; mem[10'h001] = 8'h7F;

        rst_n = 1'b0; stall = 1'b0; start = 1'b0; base_addr = '0;
        stall8 = 1'b0; start8 = 1'b0; base8 = '0;

        // Outputs while reset is held
        repeat (3) sample();
        check("reset.mem_ren", 32'(mem_ren), 32'd0);
        check("reset.mem_addr", 32'(mem_addr), 32'd0);
        check("reset.wgt_read", 32'(wgt_read), 32'd0);
        check("reset.wgt_input", 32'(wgt_input), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);

        // Nominal load: the start goes with the reset release and is taken on the first edge
        next_cycle();
        rst_n = 1'b1; start = 1'b1; base_addr = 10'h010;
        sample();
        check("nom.C0.busy", 32'(busy), 32'd0);
        build_nominal(10'h010, 8'h11, 8'h22, 8'hFF, 8'h80);
        play("nom", 8);

        // Stall high in C4..C6: the head holds 0x22, reads pause, done arrives 3 cycles late
        launch("stl", 10'h010);
        tbl.delete();
        add(1'b0, 10'h010, 1'b0, 1'b1, 10'h010, 1'b0, 8'h00, 1'b0, 1'b1); // C1
        add(1'b0, 10'h010, 1'b0, 1'b1, 10'h011, 1'b0, 8'h00, 1'b0, 1'b1); // C2
        add(1'b0, 10'h010, 1'b0, 1'b1, 10'h012, 1'b1, 8'h11, 1'b0, 1'b1); // C3
        add(1'b0, 10'h010, 1'b1, 1'b0, 10'h000, 1'b1, 8'h22, 1'b0, 1'b1); // C4
        add(1'b0, 10'h010, 1'b1, 1'b0, 10'h000, 1'b1, 8'h22, 1'b0, 1'b1); // C5
        add(1'b0, 10'h010, 1'b1, 1'b0, 10'h000, 1'b1, 8'h22, 1'b0, 1'b1); // C6
        add(1'b0, 10'h010, 1'b0, 1'b1, 10'h013, 1'b1, 8'h22, 1'b0, 1'b1); // C7
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b1, 8'hFF, 1'b0, 1'b1); // C8
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b1, 8'h80, 1'b0, 1'b1); // C9
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1, 1'b1); // C10
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0); // C11
        play("stl", 11);

        // Address wrap-around at the top of the address space
        launch("wrap", 10'h3FE);
        build_nominal(10'h3FE, 8'h5A, 8'hA5, 8'h01, 8'h7F);
        play("wrap", 8);

        // A second start in C2 with base 0x100 must be ignored
        d0 = done_cnt;
        launch("bsy", 10'h010);
        build_nominal(10'h010, 8'h11, 8'h22, 8'hFF, 8'h80);
        tbl[1].st = 1'b1; tbl[1].sb = 10'h100;
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0); // C9
        add(1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0); // C10
        play("bsy", 10);
        check("bsy.reads_at_0x100", 32'(ren100), 32'd0);
        check("bsy.done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in C4 for 2 cycles aborts the load; a fresh load after release must work
        d0 = done_cnt;
        launch("rst", 10'h010);
        build_nominal(10'h010, 8'h11, 8'h22, 8'hFF, 8'h80);
        play("rst", 3);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst.async.mem_ren", 32'(mem_ren), 32'd0);
        check("rst.async.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.async.wgt_read", 32'(wgt_read), 32'd0);
        check("rst.async.wgt_input", 32'(wgt_input), 32'd0);
        check("rst.async.busy", 32'(busy), 32'd0);
        check("rst.async.done", 32'(done), 32'd0);
        next_cycle();
        sample();
        idle_check("rst.held");
        next_cycle();
        rst_n = 1'b1;
        sample();
        idle_check("rst.rel0");
        next_cycle();
        sample();
        idle_check("rst.rel1");
        check("rst.no_done", 32'(done_cnt - d0), 32'd0);
        launch("rst.reload", 10'h010);
        play("rst.reload", 8);
        check("rst.one_done", 32'(done_cnt - d0), 32'd1);

        // Random stall on the 8-weight instance, including a load that wraps
        rnd_load("rnd0", 10'h020);
        rnd_load("rnd1", 10'h3FC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wgt_feeder.md
WGT_FEEDER -- requirements
Module: wgt_feeder

Interface
REQ-001 The block SHALL have parameter NUM_WGT, default 4, giving the number of weights loaded per start command (range 1..255).
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the weight-memory address width.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use this single clock domain only.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  global pipeline stall shared with the weight buffer.
REQ-006 start  input  1  load request, sampled only while idle.
REQ-007 base_addr  input  ADDR_W  first weight address, captured on an accepted start.
REQ-008 mem_ren  output  1  weight-memory read enable.
REQ-009 mem_addr  output  ADDR_W  weight-memory read address.
REQ-010 mem_rdata  input  8 signed  read data, valid exactly one cycle after mem_ren.
REQ-011 wgt_read  output  1  weight-valid strobe to the weight buffer.
REQ-012 wgt_input  output  8 signed  weight value, valid when wgt_read=1.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  single-cycle pulse when the last weight has been consumed.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE.
REQ-016 IDLE->RUN SHALL occur on a clock edge with start=1; base_addr SHALL be latched, and the issue and consume counters SHALL be cleared.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 A weight SHALL be consumed in any cycle with wgt_read=1 and stall=0; this matches the weight-buffer shift condition.
REQ-019 wgt_read and wgt_input SHALL hold their values unchanged while stall=1.
REQ-020 The output path SHALL be a 2-entry FIFO; wgt_read SHALL be 1 when the FIFO is non-empty; wgt_input SHALL be the FIFO head.
REQ-021 In-flight read data SHALL be written into the FIFO on the edge that ends the mem_rdata cycle, regardless of stall.
REQ-022 mem_ren SHALL be combinational and equal to 1 only when all of these hold: state=RUN, issue_cnt<NUM_WGT, and (fifo_cnt + inflight - pop) < 2, where pop is the consume condition of REQ-018.
REQ-023 mem_addr SHALL equal base_addr + issue_cnt, computed modulo 2^ADDR_W (wrap-around); issue_cnt SHALL increment on each mem_ren.
REQ-024 Throughput SHALL be 1 weight per cycle with stall=0; FIFO overflow SHALL be impossible under any stall pattern.
REQ-025 Latency: with start high in cycle C0 and stall=0, mem_ren SHALL be asserted in C1 and wgt_read in C3; the weights SHALL then be consumed in C3..C3+NUM_WGT-1.
REQ-026 Weights SHALL be delivered in increasing address order with no loss or duplication.
REQ-027 When consume_cnt reaches NUM_WGT, the state SHALL go RUN->DONE; done SHALL be 1 for exactly the one DONE cycle, followed by DONE->IDLE.
REQ-028 busy SHALL be 1 in RUN and DONE and 0 in IDLE; a new start SHALL be accepted in the cycle after DONE.
REQ-029 A stall asserted in DONE SHALL NOT extend the done pulse.
REQ-030 The block SHALL perform no sign or width conversion; wgt_input SHALL equal the mem_rdata byte bit-exactly.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE; counters, FIFO and inflight cleared; mem_ren=0, mem_addr=0, wgt_read=0, wgt_input=0, busy=0, done=0.
REQ-032 Reset asserted mid-RUN SHALL abort the load; after release the block SHALL be idle, SHALL issue no reads, and SHALL emit no done.
REQ-033 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 Nominal load: mem[0x010..0x013]=0x11,0x22,0xFF,0x80, start with base=0x010, stall=0 -> mem_ren in C1..C4, addresses 0x010..0x013; wgt_read in C3..C6 carrying +17,+34,-1,-128; done in C7; busy 0 in C8.
REQ-035 Stall mid-stream: same data, stall=1 in C4..C6 -> wgt_input holds 0x22 through C4..C6; no mem_ren while the FIFO is full; all 4 weights delivered in order; done pulse 3 cycles late.
REQ-036 Address wrap: base=0x3FE with ADDR_W=10 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-037 Start during busy: second start in C2 with base=0x100 -> ignored; no read at 0x100; exactly one done.
REQ-038 Reset mid-operation: rst_n low in C4 for 2 cycles -> all outputs 0 immediately; no done; a fresh start after release loads correctly.
REQ-039 Random stall: random stall (50%) over NUM_WGT=8 loads -> the scoreboard captures on wgt_read && !stall, sees the exact memory sequence, never more than 2 buffered weights, and one done per start.
